// File: rtl/unit_addr_router_if.sv
// ============================================================================
// Module      : unit_addr_router_if
// Description : Framed word-stream interface (valid/ready with sop/eop)
//               feeding the unit address router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface unit_addr_router_if #(
    parameter int W_WIDTH = 32
);
    logic               pkt_valid;
    logic               pkt_ready;
    logic               pkt_sop;
    logic               pkt_eop;
    logic [W_WIDTH-1:0] pkt_data;

    modport master (
        output pkt_valid,
        output pkt_sop,
        output pkt_eop,
        output pkt_data,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid,
        input  pkt_sop,
        input  pkt_eop,
        input  pkt_data,
        output pkt_ready
    );
endinterface

`default_nettype wire

// File: rtl/unit_addr_router.sv
// ============================================================================
// Module      : unit_addr_router
// Description : Decodes the unit address in each packet header and steers the
//               packet into one of four port FIFOs; drops misses and orphans.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unit_addr_router #(
    parameter int W_WIDTH = 32,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                en,
    input  wire logic [4*ADDR_W-1:0] unit_addr,
    unit_addr_router_if.slave        pkt,
    input  wire logic [3:0]          fifo_full,
    output logic      [3:0]          fifo_wr_en,
    output logic      [W_WIDTH-1:0]  fifo_data,
    output logic      [CNT_W-1:0]    fwd_cnt,
    output logic      [CNT_W-1:0]    drop_cnt,
    output logic                     err_pulse
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FWD  = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_fwd_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_err_pulse;

    logic [3:0] w_hit;
    logic       w_any_hit;
    logic [1:0] w_hit_idx;
    logic       w_ready;
    logic       w_write;
    logic [1:0] w_target;
    logic       w_accept;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_hit
            assign w_hit[k] = (pkt.pkt_data[ADDR_W-1:0] == unit_addr[k*ADDR_W +: ADDR_W]);
        end
    endgenerate

    assign w_any_hit = |w_hit;

    // Scan from the top so the lowest matching port is the last one written.
    always_comb begin
        w_hit_idx = 2'd0;
        if (w_hit[3]) w_hit_idx = 2'd3;
        if (w_hit[2]) w_hit_idx = 2'd2;
        if (w_hit[1]) w_hit_idx = 2'd1;
        if (w_hit[0]) w_hit_idx = 2'd0;
    end

    always_comb begin
        w_ready  = 1'b0;
        w_write  = 1'b0;
        w_target = r_sel;
        if (en && !rst) begin
            case (r_state)
                c_IDLE: begin
                    if (pkt.pkt_sop && w_any_hit) begin
                        w_target = w_hit_idx;
                        w_write  = 1'b1;
                        w_ready  = !fifo_full[w_hit_idx];
                    end else begin
                        w_ready  = 1'b1;
                    end
                end
                c_FWD: begin
                    w_write = 1'b1;
                    w_ready = !fifo_full[r_sel];
                end
                default: w_ready = 1'b1;
            endcase
        end
    end

    assign w_accept      = pkt.pkt_valid && w_ready;
    assign pkt.pkt_ready = w_ready;
    assign fifo_data     = pkt.pkt_data;
    assign fifo_wr_en    = (w_accept && w_write) ? (4'b0001 << w_target) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_sel       <= 2'd0;
            r_fwd_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (!pkt.pkt_sop) begin
                            r_err_pulse <= 1'b1;
                        end else if (w_any_hit) begin
                            r_sel <= w_hit_idx;
                            if (pkt.pkt_eop) begin
                                if (r_fwd_cnt != '1) r_fwd_cnt <= r_fwd_cnt + 1'b1;
                            end else begin
                                r_state <= c_FWD;
                            end
                        end else begin
                            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
                            if (!pkt.pkt_eop) r_state <= c_DROP;
                        end
                    end
                end
                c_FWD: begin
                    if (w_accept) begin
                        if (pkt.pkt_sop) r_err_pulse <= 1'b1;
                        if (pkt.pkt_eop) begin
                            if (r_fwd_cnt != '1) r_fwd_cnt <= r_fwd_cnt + 1'b1;
                            r_state <= c_IDLE;
                        end
                    end
                end
                c_DROP: begin
                    if (w_accept) begin
                        if (pkt.pkt_sop) r_err_pulse <= 1'b1;
                        if (pkt.pkt_eop) r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign fwd_cnt   = r_fwd_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign err_pulse = r_err_pulse;

endmodule

`default_nettype wire

// File: doc/unit_addr_router.md
Name: unit_addr_router

Overview:
- Ingress stage directly upstream of the four per-port fifo_top instances in the 4-switch unit address decoder.
- Accepts a word stream framed by start-of-packet (sop) and end-of-packet (eop) markers and decodes the destination unit address in the header word.
- Writes every word of the packet into the matching port FIFO, applying back-pressure from that FIFO's full flag.
- Discards unmatched and orphan traffic and keeps forward/drop statistics.

Parameters:
- W_WIDTH, 32: data word width; must equal the W_WIDTH of the downstream FIFOs.
- ADDR_W, 8: unit address width; the header carries the address in bits [ADDR_W-1:0]. Requires ADDR_W <= W_WIDTH.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  router enable; when 0, pkt_ready=0 and the state is held.
- unit_addr  in  4*ADDR_W  port k address in [k*ADDR_W +: ADDR_W]. Software changes it only while the router is idle.
- pkt_valid  in  1  input word valid.
- pkt_ready  out  1  router accepts the word this cycle.
- pkt_sop  in  1  word is a packet header.
- pkt_eop  in  1  word is the last word of the packet.
- pkt_data  in  W_WIDTH  input word.
- fifo_full  in  4  full flags of port FIFOs 0..3.
- fifo_wr_en  out  4  one-hot write strobe to port FIFO k.
- fifo_data  out  W_WIDTH  write data, common to all four FIFOs.
- fwd_cnt  out  CNT_W  packets forwarded; saturating.
- drop_cnt  out  CNT_W  packets dropped on address miss; saturating.
- err_pulse  out  1  one-cycle pulse on a framing error.

Behaviour:
- Accept condition: accept = pkt_valid & pkt_ready. The write path is combinational: fifo_data = pkt_data, and fifo_wr_en[k] = accept & (routing target == k). There is zero latency from accept to FIFO write. fifo_wr_en is never asserted when en=0.
- Registers: state (IDLE, FWD, DROP), sel[1:0], fwd_cnt, drop_cnt, err_pulse.
- Reset: state=IDLE, sel=0, counters=0, err_pulse=0. Outputs during reset: pkt_ready=0, fifo_wr_en=0.
- Address match: hit[k] = (pkt_data[ADDR_W-1:0] == unit_addr[k]). When several ports hit, the lowest index wins.
- IDLE, word with sop=1 and a hit on port k:
  - pkt_ready = !fifo_full[k]; while the FIFO is full the router stalls with no write.
  - On accept, write the word to port k and set sel=k.
  - If eop=1 on the same word (single-word packet): increment fwd_cnt and stay in IDLE. Otherwise go to FWD.
- IDLE, word with sop=1 and no hit: pkt_ready=1 and the word is discarded. Increment drop_cnt. If eop=1 stay in IDLE, otherwise go to DROP.
- IDLE, word with sop=0 (orphan): pkt_ready=1, the word is discarded, and err_pulse=1 on the next cycle.
- FWD:
  - pkt_ready = !fifo_full[sel]; each accepted word is written to port sel.
  - On an accepted word with eop=1: increment fwd_cnt and go to IDLE.
  - An accepted word with sop=1 is a framing error: it is written as ordinary data and err_pulse=1 on the next cycle.
- DROP: pkt_ready=1 and every word is discarded. An accepted word with eop=1 returns the router to IDLE. sop=1 in DROP raises err_pulse and is otherwise ignored.
- Counters saturate at all-ones and never wrap.
- err_pulse is registered: high for exactly one cycle per offending accepted word.
- Isolation: fifo_full of non-selected ports never affects pkt_ready.
- en=0 mid-packet: the router stalls and keeps state and sel; it resumes when en returns to 1.
- Reset mid-packet: the router returns to IDLE. Remaining words of the packet (sop=0) are discarded as orphans, one err_pulse each.
- unit_addr is sampled only on header words; sel holds the port for the rest of the packet.

Test Plan:
- Single-word packet: unit_addr = {0x33,0x22,0x11,0x10}, header data 0x0000_0022 with sop=eop=1 → fifo_wr_en=4'b0100 in the same cycle, fifo_data=0x22, fwd_cnt=1, state stays IDLE.
- 4-word packet to port 1 while fifo_full[1] is high for cycles 2–3 → pkt_ready=0 for those cycles and no write occurs. All 4 words land in FIFO 1 in order; fwd_cnt=1.
- Miss: header 0x0000_0055 followed by 2 words, eop on the last → pkt_ready=1 throughout, fifo_wr_en=0, drop_cnt=1, router back in IDLE.
- Duplicate addresses: unit_addr[0]=unit_addr[2]=0x10 → the packet goes only to port 0.
- Framing errors:
  - Data word with sop=0 in IDLE → discarded and one err_pulse.
  - sop inside a FWD packet → written to the current port and one err_pulse.
- Reset asserted on word 2 of a 4-word packet → fifo_wr_en=0 immediately. Words 3–4 after reset are discarded with 2 err_pulses, and counters read 0. Then force drop_cnt to saturate: all-ones plus one more miss leaves it at all-ones.
